cv32e40px_register_file_sb: RTL

Flip-flop register file for the CV32E40PX core with configurable read-port count, an in-file scoreboard for offloaded (X-interface) destination registers, and a buffered X-interface writeback path. It replaces the plain integer/FP register file inside the ID stage. Offloaded results enter a FIFO through a valid/ready handshake and retire into the array through the port-B write slot whenever the core's own port B is idle. A per-register busy bit is set at offload issue and cleared at retirement.

---
 rtl/cv32e40px_register_file_sb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cv32e40px_register_file_sb.sv
// CV32E40PX flip-flop register file with offload scoreboard and X-writeback FIFO.
// Define CV32E40PX_RF_BYPASS_EN to forward same-cycle writes/retirements to reads.
module cv32e40px_register_file_sb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FPU        = 0,
  parameter int ZFINX      = 0,
  parameter int NUM_READ   = 3,
  parameter int WB_DEPTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_READ-1:0]                 rbusy_o,
  input  logic [ADDR_WIDTH-1:0]               waddr_a_i,
  input  logic [DATA_WIDTH-1:0]               wdata_a_i,
  input  logic                                 we_a_i,
  input  logic [ADDR_WIDTH-1:0]               waddr_b_i,
  input  logic [DATA_WIDTH-1:0]               wdata_b_i,
  input  logic                                 we_b_i,
  input  logic                                 rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]               rsv_addr_i,
  input  logic                                 rsv_dual_i,
  input  logic                                 xwb_valid_i,
  output logic                                 xwb_ready_o,
  input  logic [ADDR_WIDTH-1:0]               xwb_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0]          xwb_data_i,
  input  logic                                 xwb_dual_i,
  output logic                                 wb_empty_o,
  output logic                                 sb_err_o
);

  localparam bit HAS_FP = (FPU != 0) && (ZFINX == 0);
  localparam int NREG   = HAS_FP ? 64 : 32;
  localparam int PW     = $clog2(WB_DEPTH);
  localparam int CW     = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      addr;
    logic [1:0][DATA_WIDTH-1:0] data;
    logic                       dual;
  } wb_entry_t;

  // Without an FP bank the bank-select bit aliases onto the integer bank.
  function automatic logic [ADDR_WIDTH-1:0] map(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] m;
    m = a;
    if (!HAS_FP) m[ADDR_WIDTH-1:5] = '0;
    return m;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] tgt(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  dual,
    input logic                  odd
  );
    logic [ADDR_WIDTH-1:0] t;
    t = a;
    if (dual) t[0] = odd;
    return map(t);
  endfunction

  logic [DATA_WIDTH-1:0] rf_q [NREG];
  logic [DATA_WIDTH-1:0] rf_d [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  err_q, err_d;

  wb_entry_t             fifo_q [WB_DEPTH];
  wb_entry_t             head;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         cnt_q;
  logic                  full, empty, push, pop;

  logic [NREG-1:0]       hit_a, hit_b, hit_r0, hit_r1;
  logic [NREG-1:0]       hit_rsv, hit_x;
  logic [ADDR_WIDTH-1:0] ia;

  assign full        = (cnt_q == FULL);
  assign empty       = (cnt_q == '0);
  assign xwb_ready_o = !full;
  assign wb_empty_o  = empty;
  assign sb_err_o    = err_q;
  assign push        = xwb_valid_i && !full;
  assign pop         = !empty && !we_b_i;
  assign head        = fifo_q[head_q];

  always_comb begin
    hit_a   = '0;
    hit_b   = '0;
    hit_r0  = '0;
    hit_r1  = '0;
    hit_rsv = '0;
    hit_x   = '0;
    ia      = '0;
    // Index 0 is x0: never a target.
    for (int i = 1; i < NREG; i++) begin
      ia         = ADDR_WIDTH'(i);
      hit_a[i]   = we_a_i && (map(waddr_a_i) == ia);
      hit_b[i]   = we_b_i && (map(waddr_b_i) == ia);
      hit_r0[i]  = pop &&
                   (tgt(head.addr, head.dual, 1'b0) == ia);
      hit_r1[i]  = pop && head.dual &&
                   (tgt(head.addr, 1'b1, 1'b1) == ia);
      hit_rsv[i] = rsv_valid_i &&
                   ((tgt(rsv_addr_i, rsv_dual_i, 1'b0) == ia) ||
                    (rsv_dual_i &&
                     tgt(rsv_addr_i, 1'b1, 1'b1) == ia));
      hit_x[i]   = push &&
                   ((tgt(xwb_addr_i, xwb_dual_i, 1'b0) == ia) ||
                    (xwb_dual_i &&
                     tgt(xwb_addr_i, 1'b1, 1'b1) == ia));
    end
  end

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (hit_b[i])       rf_d[i] = wdata_b_i;
      else if (hit_r0[i]) rf_d[i] = head.data[0];
      else if (hit_r1[i]) rf_d[i] = head.data[1];
      else if (hit_a[i])  rf_d[i] = wdata_a_i;
      if (hit_rsv[i]) begin
        busy_d[i] = 1'b1;
        if (busy_q[i]) err_d = 1'b1;
      end else if (hit_r0[i] || hit_r1[i]) begin
        busy_d[i] = 1'b0;
      end
      if (hit_x[i] && !busy_q[i]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      busy_q <= busy_d;
      err_q  <= err_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[tail_q] <= '{addr: xwb_addr_i,
                          data: xwb_data_i,
                          dual: xwb_dual_i};
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      rdata_o[r] = '0;
      rbusy_o[r] = 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (!rst && (HAS_FP || !raddr_i[r][5]) &&
            map(raddr_i[r]) == ADDR_WIDTH'(i)) begin
`ifdef CV32E40PX_RF_BYPASS_EN
          rdata_o[r] = rf_d[i];
          rbusy_o[r] = busy_d[i];
`else
          rdata_o[r] = rf_q[i];
          rbusy_o[r] = busy_q[i];
`endif
        end
      end
    end
  end

endmodule
